masked_sbox_scheduler: RTL and testbench

- Sequences a 16-byte, 2-share masked AES state through one shared first-order masked S-box/inverter core, one byte per cycle.
- The core is a fixed-latency, non-stallable pipeline; its default latency is 2 cycles.
- The block supplies fresh randomness to the core, tracks in-flight bytes, reassembles the shared result, and hands it off with valid/ready.
- Sits between the round-state register and the single masked S-box instance in the 2-cycle S-box design.

---
 rtl/masked_sbox_scheduler.sv | 150 +++++++++++++++
 tb/tb_masked_sbox_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_scheduler.sv
// Feeds a 16-byte, 2-share masked state through one shared masked S-box core, one byte per cycle.
// Optional: SCHED_SHARE_CLEAR_EN zeroizes share registers at handoff and blanks idle outputs.
module masked_sbox_scheduler #(
  parameter int unsigned SBOX_LAT = 2,
  parameter int unsigned RAN_W    = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_share0,
  input  logic [127:0]     in_share1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_share0,
  output logic [127:0]     out_share1,
  output logic             busy,
  input  logic             prng_valid,
  output logic             prng_ready,
  input  logic [RAN_W-1:0] prng_data,
  output logic [7:0]       sbox_in0,
  output logic [7:0]       sbox_in1,
  output logic [RAN_W-1:0] sbox_ran,
  input  logic [7:0]       sbox_out0,
  input  logic [7:0]       sbox_out1
);

  localparam int unsigned NBYTES = 16;
  localparam int unsigned IDX_W  = 5;
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [127:0]        in_sh0_q, in_sh1_q;
  logic [127:0]        res0_q, res1_q;
  logic [IDX_W-1:0]    issue_idx_q, collect_idx_q;
  logic [SBOX_LAT-1:0] vpipe_q;
  logic                accept_c, issue_c, collect_c, handoff_c;
  logic [6:0]          issue_bit_c, collect_bit_c;

  assign issue_bit_c   = {issue_idx_q[3:0], 3'b000};
  assign collect_bit_c = {collect_idx_q[3:0], 3'b000};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshakes and core-facing drive
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    prng_ready = 1'b0;
    sbox_in0   = 8'h00;
    sbox_in1   = 8'h00;
    sbox_ran   = '0;
    accept_c   = 1'b0;
    issue_c    = 1'b0;
    collect_c  = 1'b0;
    handoff_c  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
`ifndef SCHED_SHARE_CLEAR_EN
        sbox_in0 = in_sh0_q[issue_bit_c +: 8];
        sbox_in1 = in_sh1_q[issue_bit_c +: 8];
`endif
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        issue_c = (issue_idx_q < FULL_IDX) && prng_valid;
        if (issue_c) begin
          sbox_in0   = in_sh0_q[issue_bit_c +: 8];
          sbox_in1   = in_sh1_q[issue_bit_c +: 8];
          sbox_ran   = prng_data;
          prng_ready = 1'b1;
        end
        collect_c = vpipe_q[SBOX_LAT-1] && (collect_idx_q < FULL_IDX);
        if (collect_c && (collect_idx_q == LAST_IDX)) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
`ifndef SCHED_SHARE_CLEAR_EN
        sbox_in0  = in_sh0_q[issue_bit_c +: 8];
        sbox_in1  = in_sh1_q[issue_bit_c +: 8];
`endif
        if (out_ready) begin
          handoff_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Share, counter and in-flight tracking registers; shares kept in separate lanes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_sh0_q      <= '0;
      in_sh1_q      <= '0;
      res0_q        <= '0;
      res1_q        <= '0;
      issue_idx_q   <= '0;
      collect_idx_q <= '0;
      vpipe_q       <= '0;
    end else begin
      vpipe_q[0] <= issue_c;
      for (int unsigned i = 1; i < SBOX_LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
      if (accept_c) begin
        in_sh0_q      <= in_share0;
        in_sh1_q      <= in_share1;
        issue_idx_q   <= '0;
        collect_idx_q <= '0;
      end
      if (issue_c) issue_idx_q <= issue_idx_q + IDX_W'(1);
      if (collect_c) begin
        res0_q[collect_bit_c +: 8] <= sbox_out0;
        res1_q[collect_bit_c +: 8] <= sbox_out1;
        collect_idx_q              <= collect_idx_q + IDX_W'(1);
      end
`ifdef SCHED_SHARE_CLEAR_EN
      if (handoff_c) begin
        in_sh0_q <= '0;
        in_sh1_q <= '0;
        res0_q   <= '0;
        res1_q   <= '0;
      end
`endif
    end
  end

`ifdef SCHED_SHARE_CLEAR_EN
  assign out_share0 = (state_q == DONE) ? res0_q : '0;
  assign out_share1 = (state_q == DONE) ? res1_q : '0;
`else
  assign out_share0 = res0_q;
  assign out_share1 = res1_q;
`endif

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Self-checking bench for masked_sbox_scheduler with a behavioural masked AES S-box core.
module tb_masked_sbox_scheduler;
  localparam int unsigned SBOX_LAT = 2;
  localparam int unsigned RAN_W    = 30;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [127:0]     in_share0, in_share1;
  logic             out_valid, out_ready;
  logic [127:0]     out_share0, out_share1;
  logic             busy;
  logic             prng_valid, prng_ready;
  logic [RAN_W-1:0] prng_data;
  logic [7:0]       sbox_in0, sbox_in1;
  logic [RAN_W-1:0] sbox_ran;
  logic [7:0]       sbox_out0, sbox_out1;

  always #5 clk = ~clk;

  masked_sbox_scheduler #(.SBOX_LAT(SBOX_LAT), .RAN_W(RAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_share0(in_share0), .in_share1(in_share1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_share0(out_share0), .out_share1(out_share1),
    .busy(busy),
    .prng_valid(prng_valid), .prng_ready(prng_ready), .prng_data(prng_data),
    .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .sbox_ran(sbox_ran),
    .sbox_out0(sbox_out0), .sbox_out1(sbox_out1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbox_tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // Behavioural masked core: recombine, substitute, remask with the low randomness byte
  logic [7:0] core0 [SBOX_LAT];
  logic [7:0] core1 [SBOX_LAT];
  always @(posedge clk) begin
    core0[0] <= sbox_tbl[sbox_in0 ^ sbox_in1] ^ sbox_ran[7:0];
    core1[0] <= sbox_ran[7:0];
    for (int i = 1; i < int'(SBOX_LAT); i++) begin
      core0[i] <= core0[i-1];
      core1[i] <= core1[i-1];
    end
  end
  assign sbox_out0 = core0[SBOX_LAT-1];
  assign sbox_out1 = core1[SBOX_LAT-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RAN_W-1:0] rnd_ran();
    logic [RAN_W-1:0] r;
    r = RAN_W'($urandom);
    r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; prng_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One full transaction: accept, issue with a prng pattern, hold under backpressure, hand off
  task automatic run_txn(input string tag, input logic [127:0] s0, input logic [127:0] s1,
                         input int stall_mode, input int bp, output int ov,
                         output logic [127:0] r0, output logic [127:0] r1);
    int vcnt, exp_ov, pr_cnt, pr_bad, hold_bad;
    logic pv;
    logic [127:0] exp_comb;
    for (int i = 0; i < 16; i++) exp_comb[8*i +: 8] = sbox_tbl[s0[8*i +: 8] ^ s1[8*i +: 8]];
    r0 = '0; r1 = '0;
    @(posedge clk); #1;
    in_share0 = s0; in_share1 = s1; in_valid = 1'b1; prng_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_in_ready_accept"}, 128'(in_ready), 128'd1);
    vcnt = 0; exp_ov = -1; ov = -1; pr_cnt = 0; pr_bad = 0;
    for (int c = 1; c < 300 && ov < 0; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_share0 = rnd128();
      in_share1 = rnd128();
      case (stall_mode)
        0:       pv = 1'b1;
        1:       pv = !(c == 3 || c == 4 || c == 10);
        default: pv = ($urandom_range(0, 3) != 0);
      endcase
      prng_valid = pv;
      prng_data  = rnd_ran();
      @(negedge clk);
      if (prng_ready !== (pv && vcnt < 16)) pr_bad++;
      if (prng_ready && sbox_ran !== prng_data) pr_bad++;
      if (prng_ready) pr_cnt++;
      if (pv && vcnt < 16) begin
        vcnt++;
        if (vcnt == 16) exp_ov = c + int'(SBOX_LAT) + 1;
      end
      if (c == 1) check({tag, "_busy_run"}, 128'(busy), 128'd1);
      if (out_valid) ov = c;
    end
    check({tag, "_ov_latency"}, 128'(ov), 128'(exp_ov));
    if (ov < 0) begin
      pulse_reset();
      return;
    end
    check({tag, "_prng_pattern"}, 128'(pr_bad), 128'd0);
    check({tag, "_prng_count"}, 128'(pr_cnt), 128'd16);
    r0 = out_share0; r1 = out_share1;
    check({tag, "_result"}, r0 ^ r1, exp_comb);
    hold_bad = 0;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; prng_valid = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_share0 !== r0 || out_share1 !== r1
          || prng_ready !== 1'b0) hold_bad++;
    end
    check({tag, "_hold"}, 128'(hold_bad), 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_handshake"}, 128'({out_valid, in_ready}), 128'(2'b10));
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; prng_valid = 1'b1;
    @(negedge clk);
    check({tag, "_idle_after"}, 128'({in_ready, out_valid, busy, prng_ready}), 128'(4'b1000));
`ifdef SCHED_SHARE_CLEAR_EN
    check({tag, "_out_cleared"}, out_share0 | out_share1, 128'd0);
    check({tag, "_sbox_in_idle"}, 128'({sbox_in0, sbox_in1}), 128'd0);
`else
    check({tag, "_out_retained"}, out_share0 ^ out_share1, exp_comb);
`endif
  endtask

  typedef struct {
    logic [127:0] s1;
    int           stall;
    int           bp;
    logic         masked;
    int           exp_ov;
    logic [7:0]   b0, b1, b2, b15;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [127:0] pt, r0, r1, comb;
    int ov;
    for (int i = 0; i < 256; i++) sbox_tbl[i] = aes_sbox(8'(i));
    for (int i = 0; i < 16; i++) pt[8*i +: 8] = 8'(i);
    vecs[0] = '{128'd0,        0, 0, 1'b0, 19, 8'h63, 8'h7C, 8'h77, 8'h76};
    vecs[1] = '{{16{8'hA5}},   0, 0, 1'b1, 19, 8'h63, 8'h7C, 8'h77, 8'h76};
    vecs[2] = '{{16{8'hA5}},   1, 0, 1'b1, 22, 8'h63, 8'h7C, 8'h77, 8'h76};
    vecs[3] = '{128'd0,        0, 5, 1'b0, 19, 8'h63, 8'h7C, 8'h77, 8'h76};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; prng_valid = 1'b0;
    in_share0 = '0; in_share1 = '0; prng_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; prng_valid = 1'b1;
    @(negedge clk);
    check("reset_ctrl", 128'({in_ready, out_valid, busy, prng_ready}), 128'(4'b1000));
    check("reset_sbox", 128'({sbox_in0, sbox_in1, sbox_ran}), 128'd0);
    check("reset_out", out_share0 | out_share1, 128'd0);

    for (int v = 0; v < 4; v++) begin
      run_txn($sformatf("vec%0d", v), pt ^ vecs[v].s1, vecs[v].s1, vecs[v].stall, vecs[v].bp,
              ov, r0, r1);
      comb = r0 ^ r1;
      check($sformatf("vec%0d_ov_cycle", v), 128'(ov), 128'(vecs[v].exp_ov));
      check($sformatf("vec%0d_bytes", v), 128'({comb[7:0], comb[15:8], comb[23:16], comb[127:120]}),
            128'({vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b15}));
      if (vecs[v].masked) check($sformatf("vec%0d_share1_nz", v), 128'(r1 != 0), 128'd1);
    end

    // Reset in the middle of a run, then a fresh state must complete cleanly
    @(posedge clk); #1;
    in_share0 = rnd128(); in_share1 = rnd128(); in_valid = 1'b1; prng_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; prng_valid = 1'b1; prng_data = rnd_ran();
      if (c == 8) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; prng_valid = 1'b1;
    @(negedge clk);
    check("midreset_ctrl", 128'({in_ready, out_valid, prng_ready, busy}), 128'(4'b1000));
    run_txn("after_reset", rnd128(), rnd128(), 0, 1, ov, r0, r1);

    for (int t = 0; t < 6; t++)
      run_txn($sformatf("rand%0d", t), rnd128(), rnd128(), 2, int'($urandom_range(0, 4)),
              ov, r0, r1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
